rs_issue_sched: RTL

- Owns the busy state and age ordering of one reservation station (RS).
- Allocates up to two free entries per cycle to dispatch, using the lowest-index-free policy.
- Each cycle, selects the oldest busy-and-ready entry for issue to the functional unit.
- Sits between the dispatch stage, the RS entry storage (written at the allocated indices) and the functional-unit issue port.

---
 rtl/rs_issue_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: tracks per-entry busy bits and relative age,
// hands out up to two free entries per cycle to dispatch (lowest free index
// first) and picks the oldest busy-and-ready entry for issue.
module rs_issue_sched #(
    parameter int unsigned RS_ENT_NUM   = 4,
    parameter int unsigned RS_ENT_SEL   = 2,
    parameter int unsigned DP_NUM_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_dp_en,
    input  logic [DP_NUM_WIDTH-1:0] i_dp_req_num,
    output logic                    o_allocable,
    output logic                    o_alloc_vld_1,
    output logic [RS_ENT_SEL-1:0]   o_alloc_sel_1,
    output logic                    o_alloc_vld_2,
    output logic [RS_ENT_SEL-1:0]   o_alloc_sel_2,
    input  logic [RS_ENT_NUM-1:0]   i_rdy_vec,
    input  logic                    i_issue_stall,
    output logic                    o_issue_vld,
    output logic [RS_ENT_SEL-1:0]   o_issue_sel,
    output logic [RS_ENT_NUM-1:0]   o_busy_vec
);

    // Free-count arithmetic needs one extra bit so that 2 <= 1+1 works at width 2.
    localparam int unsigned CNT_W = DP_NUM_WIDTH + 1;

    // busy_q[i]: entry i holds an instruction.
    // age_q[i][j]: entry i is older than entry j (diagonal always 0).
    logic [RS_ENT_NUM-1:0]                 busy_q;
    logic [RS_ENT_NUM-1:0]                 busy_d;
    logic [RS_ENT_NUM-1:0][RS_ENT_NUM-1:0] age_q;
    logic [RS_ENT_NUM-1:0][RS_ENT_NUM-1:0] age_d;

    logic                  vld_1;
    logic                  vld_2;
    logic [RS_ENT_SEL-1:0] sel_1;
    logic [RS_ENT_SEL-1:0] sel_2;
    logic [CNT_W-1:0]      free_cnt;
    logic [CNT_W-1:0]      req_ext;
    logic                  allocable;

    logic [RS_ENT_NUM-1:0] cand;
    logic [RS_ENT_NUM-1:0] older;
    logic [RS_ENT_NUM-1:0] win;
    logic                  win_any;
    logic [RS_ENT_SEL-1:0] win_sel;
    logic                  issue_vld;

    logic                  issue_fire;
    logic                  dp_fire;
    logic                  alloc_1;
    logic                  alloc_2;
    logic [RS_ENT_NUM-1:0] busy_kept;

    // Lowest and second-lowest free entries from the registered busy vector.
    always_comb begin
        vld_1 = 1'b0;
        vld_2 = 1'b0;
        sel_1 = '0;
        sel_2 = '0;
        for (int unsigned i = 0; i < RS_ENT_NUM; i++) begin
            if (!busy_q[i]) begin
                if (!vld_1) begin
                    vld_1 = 1'b1;
                    sel_1 = RS_ENT_SEL'(i);
                end else if (!vld_2) begin
                    vld_2 = 1'b1;
                    sel_2 = RS_ENT_SEL'(i);
                end
            end
        end
    end

    // Dispatch may proceed only if the request fits in the free entries found.
    always_comb begin
        free_cnt  = CNT_W'(vld_1) + CNT_W'(vld_2);
        req_ext   = CNT_W'(i_dp_req_num);
        allocable = (req_ext <= free_cnt);
    end

    // An entry wins issue when it is a candidate and no other candidate is older.
    always_comb begin
        cand  = busy_q & i_rdy_vec;
        older = '0;
        for (int unsigned i = 0; i < RS_ENT_NUM; i++) begin
            for (int unsigned j = 0; j < RS_ENT_NUM; j++) begin
                if ((j != i) && cand[j] && age_q[j][i]) begin
                    older[i] = 1'b1;
                end
            end
        end
        win = cand & ~older;
    end

    // Encode the (single) winner; index 0 when nothing is ready.
    always_comb begin
        win_any = 1'b0;
        win_sel = '0;
        for (int unsigned i = 0; i < RS_ENT_NUM; i++) begin
            if (win[i] && !win_any) begin
                win_any = 1'b1;
                win_sel = RS_ENT_SEL'(i);
            end
        end
        issue_vld = (|cand) & ~i_flush;
    end

    // Qualify this cycle's issue and dispatch events.
    always_comb begin
        issue_fire = issue_vld & ~i_issue_stall;
        dp_fire    = i_dp_en & allocable & ~i_flush;
        alloc_1    = dp_fire & (i_dp_req_num >= DP_NUM_WIDTH'(1));
        alloc_2    = dp_fire & (i_dp_req_num == DP_NUM_WIDTH'(2));
        busy_kept  = busy_q;
        if (issue_fire) begin
            busy_kept[win_sel] = 1'b0;
        end
    end

    // Next busy vector and age matrix; flush wipes both.
    always_comb begin
        busy_d = busy_kept;
        age_d  = age_q;
        if (alloc_1) begin
            busy_d[sel_1] = 1'b1;
            for (int unsigned j = 0; j < RS_ENT_NUM; j++) begin
                age_d[sel_1][j] = 1'b0;
                if (RS_ENT_SEL'(j) != sel_1) begin
                    age_d[j][sel_1] = busy_kept[j];
                end
            end
        end
        if (alloc_2) begin
            busy_d[sel_2] = 1'b1;
            for (int unsigned j = 0; j < RS_ENT_NUM; j++) begin
                age_d[sel_2][j] = 1'b0;
                if (RS_ENT_SEL'(j) != sel_2) begin
                    age_d[j][sel_2] = busy_kept[j];
                end
            end
            // Slot 1 is the older instruction of the pair.
            age_d[sel_1][sel_2] = 1'b1;
            age_d[sel_2][sel_1] = 1'b0;
        end
        if (i_flush) begin
            busy_d = '0;
            age_d  = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
            age_q  <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
        end
    end

    // Output drive.
    always_comb begin
        o_allocable   = allocable;
        o_alloc_vld_1 = vld_1;
        o_alloc_sel_1 = sel_1;
        o_alloc_vld_2 = vld_2;
        o_alloc_sel_2 = sel_2;
        o_issue_vld   = issue_vld;
        o_issue_sel   = win_sel;
        o_busy_vec    = busy_q;
    end

endmodule
